// File: rtl/alu_rr_sched.sv
// alu_rr_sched: shares one 16-bit, 8-op ALU between two requesters.
// Arbitration is round-robin with a one-bit priority pointer.
// Only one operation is in flight at a time: IDLE -> EXEC -> RESP.
// The result is registered and returned on a shared response channel
// that is tagged with the id of the requester that issued it.
module alu_rr_sched #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_a0,
    input  logic [15:0] req_b0,
    input  logic [2:0]  req_op0,
    input  logic [15:0] req_a1,
    input  logic [15:0] req_b1,
    input  logic [2:0]  req_op1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_y,
    output logic        rsp_cout,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic        id_q, id_d;
    logic [15:0] y_q, y_d;
    logic        cout_q, cout_d;
    logic        rid_q, rid_d;

    logic [1:0]  grant;
    logic [15:0] alu_y;
    logic        alu_cout;
    logic [16:0] sum;
    logic [16:0] diff;

    // Arbitration: a lone valid requester wins; on a tie the pointer decides.
    // No grant while reset is asserted, since reset overrides every input.
    always_comb begin
        grant = 2'b00;
        if (state_q == S_IDLE && !rst) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // Shared ALU, driven only from the captured operand registers.
    // Bit 16 of the 17-bit difference is the borrow (set iff a < b).
    always_comb begin
        sum      = {1'b0, a_q} + {1'b0, b_q};
        diff     = {1'b0, a_q} - {1'b0, b_q};
        alu_y    = 16'h0000;
        alu_cout = 1'b0;
        case (op_q)
            3'd0: begin
                alu_y    = sum[15:0];
                alu_cout = sum[16];
            end
            3'd1: begin
                alu_y    = diff[15:0];
                alu_cout = diff[16];
            end
            3'd2:    alu_y = (a_q < b_q) ? a_q : b_q;
            3'd3:    alu_y = (a_q > b_q) ? a_q : b_q;
            3'd4:    alu_y = a_q & b_q;
            3'd5:    alu_y = a_q | b_q;
            3'd6:    alu_y = a_q ^ b_q;
            default: alu_y = ~(a_q ^ b_q);
        endcase
    end

    // Next-state logic: capture on a handshake, register the result, wait for accept.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        id_d    = id_q;
        y_d     = y_q;
        cout_d  = cout_q;
        rid_d   = rid_q;
        case (state_q)
            S_IDLE: begin
                if (grant != 2'b00) begin
                    id_d    = grant[1];
                    a_d     = grant[1] ? req_a1  : req_a0;
                    b_d     = grant[1] ? req_b1  : req_b0;
                    op_d    = grant[1] ? req_op1 : req_op0;
                    ptr_d   = ~grant[1];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                y_d     = alu_y;
                cout_d  = alu_cout;
                rid_d   = id_q;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= RR_INIT;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            op_q    <= 3'd0;
            id_q    <= 1'b0;
            y_q     <= 16'h0000;
            cout_q  <= 1'b0;
            rid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            id_q    <= id_d;
            y_q     <= y_d;
            cout_q  <= cout_d;
            rid_q   <= rid_d;
        end
    end

    assign req_ready = grant;
    assign rsp_valid = (state_q == S_RESP);
    assign busy      = (state_q == S_EXEC) || (state_q == S_RESP);
    assign rsp_id    = rid_q;
    assign rsp_y     = y_q;
    assign rsp_cout  = cout_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Testbench for alu_rr_sched: two instances (RR_INIT=0 and RR_INIT=1) share
// one stimulus stream; a transaction-level model per instance predicts every
// output each cycle, and directed sequences pin hand-computed results.
module tb_alu_rr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_a0, req_b0, req_a1, req_b1;
    logic [2:0]  req_op0, req_op1;
    logic        rsp_ready;

    logic [1:0]  rdy [2];
    logic        rv  [2];
    logic        rid [2];
    logic [15:0] ry  [2];
    logic        rc  [2];
    logic        bsy [2];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    alu_rr_sched #(.RR_INIT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
        .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
        .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_id(rid[0]),
        .rsp_y(ry[0]), .rsp_cout(rc[0]), .busy(bsy[0])
    );

    alu_rr_sched #(.RR_INIT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
        .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
        .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_id(rid[1]),
        .rsp_y(ry[1]), .rsp_cout(rc[1]), .busy(bsy[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference ALU in plain integer arithmetic; returns {cout, y}.
    function automatic logic [16:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int ai, bi, r;
        logic c;
        ai = int'(a);
        bi = int'(b);
        c  = 1'b0;
        case (op)
            3'd0: begin r = ai + bi; c = (r > 65535); r = r % 65536; end
            3'd1: begin c = (ai < bi); r = (ai - bi + 65536) % 65536; end
            3'd2: r = (ai < bi) ? ai : bi;
            3'd3: r = (ai > bi) ? ai : bi;
            3'd4: r = ai & bi;
            3'd5: r = ai | bi;
            3'd6: r = ai ^ bi;
            default: r = 65535 - (ai ^ bi);
        endcase
        return {c, r[15:0]};
    endfunction

    // Model state per instance: age -1 = waiting for a request,
    // 0 = operation accepted last edge, 1 = response outstanding.
    bit          m_ok  [2];
    int          m_age [2];
    bit          m_ptr [2];
    logic [15:0] m_a   [2];
    logic [15:0] m_b   [2];
    logic [2:0]  m_op  [2];
    bit          m_id  [2];
    logic [15:0] m_y   [2];
    logic        m_c   [2];
    logic        m_rid [2];

    // Per-cycle compare against the model, then advance the model to the next edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [1:0]  eg;
            logic [16:0] res;
            eg = 2'b00;
            if (m_ok[k] && !rst && m_age[k] < 0) begin
                if (req_valid == 2'b11) eg = m_ptr[k] ? 2'b10 : 2'b01;
                else                    eg = req_valid;
            end
            if (m_ok[k]) begin
                chk($sformatf("dut%0d.req_ready", k), rdy[k], eg);
                chk($sformatf("dut%0d.busy", k), bsy[k], m_age[k] >= 0);
                chk($sformatf("dut%0d.rsp_valid", k), rv[k], m_age[k] >= 1);
                chk($sformatf("dut%0d.rsp_y", k), ry[k], m_y[k]);
                chk($sformatf("dut%0d.rsp_cout", k), rc[k], m_c[k]);
                chk($sformatf("dut%0d.rsp_id", k), rid[k], m_rid[k]);
            end
            if (rst) begin
                m_ok[k]  = 1'b1;
                m_age[k] = -1;
                m_ptr[k] = (k == 1);
                m_y[k]   = 16'h0000;
                m_c[k]   = 1'b0;
                m_rid[k] = 1'b0;
            end else if (m_ok[k]) begin
                if (m_age[k] < 0) begin
                    if (eg != 2'b00) begin
                        m_id[k]  = eg[1];
                        m_a[k]   = eg[1] ? req_a1 : req_a0;
                        m_b[k]   = eg[1] ? req_b1 : req_b0;
                        m_op[k]  = eg[1] ? req_op1 : req_op0;
                        m_ptr[k] = !eg[1];
                        m_age[k] = 0;
                    end
                end else if (m_age[k] == 0) begin
                    res      = ref_alu(m_op[k], m_a[k], m_b[k]);
                    m_y[k]   = res[15:0];
                    m_c[k]   = res[16];
                    m_rid[k] = m_id[k];
                    m_age[k] = 1;
                end else if (rsp_ready) begin
                    m_age[k] = -1;
                end
            end
        end
    end

    task automatic drive(input int r, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        if (r == 0) begin req_a0 = a; req_b0 = b; req_op0 = op; end
        else        begin req_a1 = a; req_b1 = b; req_op1 = op; end
    endtask

    // Waits (bounded) for the negedge at which dut0 grants requester r.
    task automatic wait_grant(input int r, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy[0][r] && n < 20);
        chk({nm, ".grant_timeout"}, n < 20, 1);
    endtask

    // One operation from requester r with rsp_ready high; checks latency and result.
    // Called at posedge+1 with dut0 idle, returns at posedge+1 after acceptance.
    task automatic run_op(input int r, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                          input logic [15:0] ey, input logic ec, input string nm);
        drive(r, a, b, op);
        req_valid[r] = 1'b1;
        wait_grant(r, nm);
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        @(negedge clk);
        chk({nm, ".exec_rsp_valid"}, rv[0], 0);
        chk({nm, ".exec_busy"}, bsy[0], 1);
        @(negedge clk);
        chk({nm, ".rsp_valid"}, rv[0], 1);
        chk({nm, ".rsp_y"}, ry[0], ey);
        chk({nm, ".rsp_cout"}, rc[0], ec);
        chk({nm, ".rsp_id"}, rid[0], r);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    logic [15:0] sweep_y [8];
    bit          gq0 [$];
    bit          gq1 [$];

    initial begin
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
        drive(0, 16'h0, 16'h0, 3'd0);
        drive(1, 16'h0, 16'h0, 3'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state, literal.
        @(negedge clk);
        chk("reset.rsp_valid", rv[0], 0);
        chk("reset.rsp_y", ry[0], 16'h0000);
        chk("reset.rsp_cout", rc[0], 0);
        chk("reset.rsp_id", rid[0], 0);
        chk("reset.busy", bsy[0], 0);
        chk("reset.req_ready", rdy[0], 2'b00);
        @(posedge clk); #1;

        // Add with carry out, then both subtract directions.
        run_op(0, 16'hFFFF, 16'h0001, 3'd0, 16'h0000, 1'b1, "add_carry");
        run_op(1, 16'h0003, 16'h0005, 3'd1, 16'hFFFE, 1'b1, "sub_borrow");
        run_op(1, 16'h0005, 16'h0003, 3'd1, 16'h0002, 1'b0, "sub_noborrow");

        // Op sweep, also pinning the reference ALU to hand-computed values.
        sweep_y = '{16'hB4B4, 16'h9696, 16'h0F0F, 16'hA5A5, 16'h0505, 16'hAFAF, 16'hAAAA, 16'h5555};
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ref_alu.op%0d", i), ref_alu(3'(i), 16'hA5A5, 16'h0F0F), {1'b0, sweep_y[i]});
            run_op(i % 2, 16'hA5A5, 16'h0F0F, 3'(i), sweep_y[i], 1'b0, $sformatf("sweep.op%0d", i));
        end

        // Backpressure: response held for 5 cycles while both requesters wait.
        rsp_ready = 1'b0;
        drive(0, 16'h1234, 16'h00FF, 3'd2);
        req_valid = 2'b01;
        wait_grant(0, "bp");
        @(posedge clk); #1;
        drive(0, 16'h1111, 16'h2222, 3'd4);
        drive(1, 16'h3333, 16'h4444, 3'd5);
        req_valid = 2'b11;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp.rsp_valid", rv[0], 1);
            chk("bp.rsp_y", ry[0], 16'h00FF);
            chk("bp.req_ready", rdy[0], 2'b00);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp.next_grant", rdy[0], 2'b10);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (2) @(posedge clk);
        #1;

        // Fairness with both valid continuously.
        do_reset();
        req_valid = 2'b11;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (rdy[0] != 2'b00) gq0.push_back(rdy[0][1]);
            if (rdy[1] != 2'b00) gq1.push_back(rdy[1][1]);
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rr.grant_count1", gq1.size() >= 4, 1);
        chk("rr.grant_count0", gq0.size() >= 4, 1);
        for (int i = 0; i < 4 && i < gq1.size() && i < gq0.size(); i++) begin
            chk($sformatf("rr.init1.grant%0d", i), gq1[i], (i % 2 == 0));
            chk($sformatf("rr.init0.grant%0d", i), gq0[i], (i % 2 == 1));
        end

        // Reset during EXEC drops the operation and restores the pointer.
        run_op(0, 16'h0001, 16'h0002, 3'd0, 16'h0003, 1'b0, "pre_drop");
        drive(1, 16'h7777, 16'h1111, 3'd0);
        req_valid = 2'b10;
        wait_grant(1, "drop");
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drop.rsp_valid", rv[0], 0);
            chk("drop.busy", bsy[0], 0);
        end
        @(posedge clk); #1;
        req_valid = 2'b11;
        @(negedge clk);
        chk("drop.ptr_init0", rdy[0], 2'b01);
        chk("drop.ptr_init1", rdy[1], 2'b10);
        @(posedge clk); #1;
        req_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        // Randomized traffic; the per-cycle model does the checking.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [1:0] hs;
            @(negedge clk);
            hs = req_valid & rdy[0];
            @(posedge clk); #1;
            rst = ($urandom_range(0, 499) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int r = 0; r < 2; r++) begin
                if (!req_valid[r] || hs[r]) begin
                    req_valid[r] = ($urandom_range(0, 2) == 0);
                    drive(r, rnd16(), rnd16(), 3'($urandom_range(0, 7)));
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[r] = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
